// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - AXI4-Lite initiator with a valid/ready command port and response port
module axi_lite_master #(
  parameter int         DATA_WIDTH = 32,
  parameter int         ADDR_WIDTH = 5,
  parameter logic [2:0] PROT       = 3'b000
) (
  input  logic                    axi_clk,
  input  logic                    axi_reset,
  // command port
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  // response port
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  // AW channel
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [2:0]              axi_awprot,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  // W channel
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  // B channel
  input  logic [1:0]              axi_bresp,
  input  logic                    axi_bvalid,
  output logic                    axi_bready,
  // AR channel
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic [2:0]              axi_arprot,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  // R channel
  input  logic [DATA_WIDTH-1:0]   axi_rdata,
  input  logic [1:0]              axi_rresp,
  input  logic                    axi_rvalid,
  output logic                    axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD,
    S_RD_DATA,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                    write_q, write_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_resp_q, rsp_resp_d;

  // All bus-facing controls decode straight from the state register, so a
  // reset edge clears every valid/ready on the very next cycle.
  assign cmd_ready   = axi_reset && (state_q == S_IDLE);
  assign axi_awvalid = (state_q == S_WR) && !aw_done_q;
  assign axi_wvalid  = (state_q == S_WR) && !w_done_q;
  assign axi_bready  = (state_q == S_WR_RESP);
  assign axi_arvalid = (state_q == S_RD);
  assign axi_rready  = (state_q == S_RD_DATA);
  assign rsp_valid   = (state_q == S_DONE);

  assign axi_awaddr  = addr_q;
  assign axi_araddr  = addr_q;
  assign axi_awprot  = PROT;
  assign axi_arprot  = PROT;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign rsp_write   = write_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;

  // Next-state logic: one transaction at a time, AW and W completion tracked independently
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    write_d     = write_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          write_d   = cmd_write;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? S_WR : S_RD;
        end
      end
      S_WR: begin
        if (axi_awvalid && axi_awready) aw_done_d = 1'b1;
        if (axi_wvalid && axi_wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)      state_d   = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (axi_bvalid) begin
          rsp_resp_d  = axi_bresp;
          rsp_rdata_d = '0;
          state_d     = S_DONE;
        end
      end
      S_RD: begin
        if (axi_arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (axi_rvalid) begin
          rsp_rdata_d = axi_rdata;
          rsp_resp_d  = axi_rresp;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured-transaction registers with synchronous active-low reset
  always_ff @(posedge axi_clk) begin
    if (!axi_reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      write_q     <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      write_q     <= write_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

endmodule
